// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch bank: resolution modes, limits and a
// popcount helper sized for the widest legal bank.
package sr_pkg;

    typedef enum logic [1:0] {
        SR_HOLD    = 2'd0,
        SR_SET_DOM = 2'd1,
        SR_RST_DOM = 2'd2,
        SR_TOGGLE  = 2'd3
    } sr_mode_e;

    localparam int SR_MAX_WIDTH = 32;
    localparam int SR_MAX_SYNC  = 3;
    localparam int SR_CNT_MAX_W = $clog2(SR_MAX_WIDTH + 1);

    function automatic logic [SR_CNT_MAX_W-1:0] popcount(input logic [SR_MAX_WIDTH-1:0] v);
        logic [SR_CNT_MAX_W-1:0] n;
        n = '0;
        for (int i = 0; i < SR_MAX_WIDTH; i++) begin
            n = n + SR_CNT_MAX_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sr_latch_bank_if.sv
// Request/status bundle of the SR latch bank; master drives requests,
// slave (the bank) returns stored state and status.
interface sr_latch_bank_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] en;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] changed;
    logic             conflict;
    logic [CNT_W-1:0] count;

    modport master (
        output s, r, en, clr,
        input  q, q_n, changed, conflict, count
    );

    modport slave (
        input  s, r, en, clr,
        output q, q_n, changed, conflict, count
    );

endinterface

// File: rtl/sr_cell.sv
// One SR storage channel: next-state resolution, state flop and change pulse.
module sr_cell
    import sr_pkg::*;
#(
    parameter logic [1:0] MODE = SR_HOLD,
    parameter logic       INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic s,
    input  logic r,
    input  logic en,
    output logic q,
    output logic changed,
    output logic conflict_evt
);

    logic q_next;

    always_comb begin
        // NOTE: default first so every path assigns q_next and no latch is inferred.
        q_next = q;
        if (clr) begin
            q_next = 1'b0;
        end else if (en) begin
            case ({s, r})
                2'b10:   q_next = 1'b1;
                2'b01:   q_next = 1'b0;
                2'b11: begin
                    case (sr_mode_e'(MODE))
                        SR_SET_DOM: q_next = 1'b1;
                        SR_RST_DOM: q_next = 1'b0;
                        SR_TOGGLE:  q_next = ~q;
                        default:    q_next = q;
                    endcase
                end
                default: q_next = q;
            endcase
        end
    end

    // clr overrides the per-channel request, including its conflict report.
    assign conflict_evt = en & s & r & ~clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= INIT;
            changed <= 1'b0;
        end else begin
            // NOTE: non-blocking, so changed compares against the pre-edge q.
            q       <= q_next;
            changed <= q_next ^ q;
        end
    end

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of WIDTH clocked SR channels with optional input synchroniser,
// sticky conflict flag and a popcount of the stored state.
module sr_latch_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [1:0]       MODE        = 2'd0,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}}
) (
    input logic            clk,
    input logic            rst,
    sr_latch_bank_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] ss;
    logic [WIDTH-1:0] rr;
    logic [WIDTH-1:0] ee;
    logic [WIDTH-1:0] q_int;
    logic [WIDTH-1:0] chg_int;
    logic [WIDTH-1:0] evt;
    logic             conflict_q;

    if (SYNC_STAGES < 0 || SYNC_STAGES > SR_MAX_SYNC) begin : g_bad_sync
        $error("sr_latch_bank: SYNC_STAGES must be in 0..3");
    end

    if (WIDTH < 1 || WIDTH > SR_MAX_WIDTH) begin : g_bad_width
        $error("sr_latch_bank: WIDTH must be in 1..32");
    end

    if (SYNC_STAGES == 0) begin : g_nosync
        assign ss = bus.s;
        assign rr = bus.r;
        assign ee = bus.en;
    end else begin : g_sync
        logic [WIDTH-1:0] s_st [SYNC_STAGES];
        logic [WIDTH-1:0] r_st [SYNC_STAGES];
        logic [WIDTH-1:0] e_st [SYNC_STAGES];

        always_ff @(posedge clk) begin
            if (rst) begin
                // NOTE: these arrays are discrete flops, not RAM, so they take the reset.
                for (int k = 0; k < SYNC_STAGES; k++) begin
                    s_st[k] <= '0;
                    r_st[k] <= '0;
                    e_st[k] <= '0;
                end
            end else begin
                s_st[0] <= bus.s;
                r_st[0] <= bus.r;
                e_st[0] <= bus.en;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    s_st[k] <= s_st[k-1];
                    r_st[k] <= r_st[k-1];
                    e_st[k] <= e_st[k-1];
                end
            end
        end

        assign ss = s_st[SYNC_STAGES-1];
        assign rr = r_st[SYNC_STAGES-1];
        assign ee = e_st[SYNC_STAGES-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE (MODE),
            .INIT (INIT[i])
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .clr          (bus.clr),
            .s            (ss[i]),
            .r            (rr[i]),
            .en           (ee[i]),
            .q            (q_int[i]),
            .changed      (chg_int[i]),
            .conflict_evt (evt[i])
        );
    end

    // Sticky: only rst clears it, clr deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else if (|evt) begin
            conflict_q <= 1'b1;
        end
    end

    assign bus.q        = q_int;
    assign bus.q_n      = ~q_int;
    assign bus.changed  = chg_int;
    assign bus.conflict = conflict_q;
    assign bus.count    = CNT_W'(popcount(SR_MAX_WIDTH'(q_int)));

endmodule

// File: tb/tb_sr_latch_bank.sv
// Scoreboard bench: four banks (one per MODE, mixed sync depth and INIT)
// share stimulus and are compared against a per-edge behavioural model.
module tb_sr_latch_bank;
    import sr_pkg::*;

    localparam int W    = 8;
    localparam int NDUT = 4;
    localparam int CW   = $clog2(W + 1);

    localparam logic [NDUT-1:0][1:0]   MODE_P = {2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [NDUT-1:0][1:0]   SYNC_P = {2'd0, 2'd1, 2'd0, 2'd2};
    localparam logic [NDUT-1:0][W-1:0] INIT_P = {8'h00, 8'h3C, 8'h00, 8'hA5};

    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic [W-1:0] en;
    } in_t;

    typedef struct {
        logic [NDUT-1:0][W-1:0]  q;
        logic [NDUT-1:0][W-1:0]  chg;
        logic [NDUT-1:0]         conf;
        logic [NDUT-1:0][CW-1:0] cnt;
        string                   tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         clr;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] en;

    logic [NDUT-1:0][W-1:0]  q_o;
    logic [NDUT-1:0][W-1:0]  qn_o;
    logic [NDUT-1:0][W-1:0]  chg_o;
    logic [NDUT-1:0]         conf_o;
    logic [NDUT-1:0][CW-1:0] cnt_o;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sr_latch_bank_if #(.WIDTH(W)) bus ();

        assign bus.s   = s;
        assign bus.r   = r;
        assign bus.en  = en;
        assign bus.clr = clr;
        assign q_o[g]    = bus.q;
        assign qn_o[g]   = bus.q_n;
        assign chg_o[g]  = bus.changed;
        assign conf_o[g] = bus.conflict;
        assign cnt_o[g]  = bus.count;

        sr_latch_bank #(
            .WIDTH       (W),
            .MODE        (MODE_P[g]),
            .SYNC_STAGES (int'(SYNC_P[g])),
            .INIT        (INIT_P[g])
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // Reference state: stored q, sticky conflict, and inputs of the last three edges.
    logic [NDUT-1:0][W-1:0] m_q;
    logic [NDUT-1:0]        m_conf;
    in_t                    hist [1:3];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Apply the specification's rules for one clock edge and queue the outcome.
    task automatic model_edge(input in_t cur, input logic mclr, input logic mrst, input string tag);
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            in_t          eff;
            logic [W-1:0] nq;
            int           ones;
            eff = (SYNC_P[d] == 2'd0) ? cur : hist[int'(SYNC_P[d])];
            if (mrst) begin
                nq        = INIT_P[d];
                e.chg[d]  = '0;
                m_conf[d] = 1'b0;
            end else begin
                nq = m_q[d];
                if (mclr) begin
                    nq = '0;
                end else begin
                    for (int i = 0; i < W; i++) begin
                        if (eff.en[i]) begin
                            if (eff.s[i] && !eff.r[i]) nq[i] = 1'b1;
                            if (!eff.s[i] && eff.r[i]) nq[i] = 1'b0;
                            if (eff.s[i] && eff.r[i]) begin
                                m_conf[d] = 1'b1;
                                if (MODE_P[d] == 2'd1) nq[i] = 1'b1;
                                if (MODE_P[d] == 2'd2) nq[i] = 1'b0;
                                if (MODE_P[d] == 2'd3) nq[i] = ~m_q[d][i];
                            end
                        end
                    end
                end
                e.chg[d] = nq ^ m_q[d];
            end
            m_q[d] = nq;
            ones = 0;
            for (int i = 0; i < W; i++) ones += int'(nq[i]);
            e.q[d]    = nq;
            e.conf[d] = m_conf[d];
            e.cnt[d]  = CW'(ones);
        end
        if (mrst) begin
            for (int k = 1; k <= 3; k++) hist[k] = '0;
        end else begin
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = cur;
        end
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [W-1:0] ts, input logic [W-1:0] tr, input logic [W-1:0] ten,
                         input logic tclr, input logic trst, input string tag);
        in_t cur;
        @(negedge clk);
        #1;
        s   = ts;
        r   = tr;
        en  = ten;
        clr = tclr;
        rst = trst;
        cur.s  = ts;
        cur.r  = tr;
        cur.en = ten;
        model_edge(cur, tclr, trst, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0, 1'b0, tag);
    endtask

    // Monitor: every edge yields one expectation, compared half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int d = 0; d < NDUT; d++) begin
                    check($sformatf("%s d%0d q", e.tag, d), q_o[d], e.q[d]);
                    check($sformatf("%s d%0d q_n", e.tag, d), qn_o[d], ~e.q[d]);
                    check($sformatf("%s d%0d changed", e.tag, d), chg_o[d], e.chg[d]);
                    check($sformatf("%s d%0d conflict", e.tag, d), W'(conf_o[d]), W'(e.conf[d]));
                    check($sformatf("%s d%0d count", e.tag, d), W'(cnt_o[d]), W'(e.cnt[d]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        s   = '0;
        r   = '0;
        en  = '0;
        m_q    = '0;
        m_conf = '0;
        for (int k = 1; k <= 3; k++) hist[k] = '0;

        drive('0, '0, '0, 1'b0, 1'b1, "reset");
        drive('0, '0, '0, 1'b0, 1'b1, "reset");
        drive('0, '0, '0, 1'b0, 1'b0, "post_reset");
        check("reset_const q", q_o[0], 8'hA5);
        check("reset_const q_n", qn_o[0], 8'h5A);
        check("reset_const count", W'(cnt_o[0]), 8'd4);
        idle(1, "post_reset");

        drive(8'h0F, '0, 8'hFF, 1'b0, 1'b0, "set_0f");
        idle(3, "set_0f");
        drive('0, 8'h03, 8'hFF, 1'b0, 1'b0, "rst_03");
        idle(3, "rst_03");

        for (int i = 0; i < 5; i++) drive(8'hFF, '0, 8'h00, 1'b0, 1'b0, "gated");
        drive(8'hFF, '0, 8'h80, 1'b0, 1'b0, "gate_80");
        idle(3, "gate_80");

        drive('0, '0, '0, 1'b0, 1'b1, "reset2");
        for (int i = 0; i < 3; i++) drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0, "conflict");
        idle(4, "conflict");

        drive(8'hFF, '0, 8'hFF, 1'b0, 1'b0, "fill");
        idle(3, "fill");
        drive(8'hFF, '0, 8'hFF, 1'b1, 1'b0, "clr");
        idle(4, "clr");

        for (int i = 0; i < 4; i++) drive(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, "toggle");
        drive(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, "toggle_rst");
        idle(4, "flush");

        for (int i = 0; i < 400; i++) begin
            drive(W'($urandom), W'($urandom), W'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0), "random");
        end
        idle(4, "tail");

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_latch_bank.md
Name: sr_latch_bank

Overview:
- Clocked, parametrised successor to the gate-level gated SR latch.
- Holds WIDTH independent SR storage channels, each with its own gate enable.
- Resolution of simultaneous set and reset is selectable: hold, set-dominant, reset-dominant or toggle (JK).
- Optional input synchroniser for asynchronous board inputs; drives LEDs and downstream logic with change pulses and a conflict flag.

Parameters:
- WIDTH, 8, number of channels (1..32).
- MODE, 2'd0, S&R-both-asserted resolution: 0 HOLD, 1 SET_DOM, 2 RST_DOM, 3 TOGGLE.
- SYNC_STAGES, 2, flip-flop synchroniser depth on s/r/en (0 = none, max 3).
- INIT, {WIDTH{1'b0}}, per-channel value of q after reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- s  input  WIDTH  per-channel set request.
- r  input  WIDTH  per-channel reset request.
- en  input  WIDTH  per-channel gate enable; s/r ignored where en=0.
- clr  input  1  synchronous clear of all channels to 0, unsynchronised.
- q  output  WIDTH  stored state.
- q_n  output  WIDTH  always exactly ~q.
- changed  output  WIDTH  one-cycle pulse per channel whose q changed on the previous edge.
- conflict  output  1  sticky flag: some enabled channel saw s&r together.
- count  output  $clog2(WIDTH+1)  number of channels with q=1.

Behaviour:
- Reset (rst=1 at clk edge) has top priority:
  - q=INIT, q_n=~INIT, changed=0, conflict=0.
  - Synchroniser stages cleared to 0.
- Synchroniser: s, r and en each pass through SYNC_STAGES registers. The synchronised copies (ss, rr, ee) drive the next-state logic.
- clr (after rst, before everything else): q<=0 on the edge. changed pulses only for channels that were 1. conflict is unaffected.
- Per channel i, when not rst and not clr, with ee[i]=1:
  - s=1, r=0: q<=1.
  - s=0, r=1: q<=0.
  - s=0, r=0: hold.
  - s=1, r=1:
    - MODE 0: hold, conflict<=1.
    - MODE 1: q<=1.
    - MODE 2: q<=0.
    - MODE 3: q<=~q.
  - conflict is set on any s&r&en event in every mode. It clears only on rst.
- ee[i]=0: hold regardless of s/r; no conflict.
- Latency: an input held from before edge n is reflected in q after edge n+SYNC_STAGES. With SYNC_STAGES=0, q changes on the first edge sampling the input.
- changed[i] is registered: changed<=q_next^q. It is high for exactly the cycle after q changes. It is 0 on re-set of an already-set channel.
- TOGGLE with s&r held: q toggles every cycle and changed stays high continuously.
- count is combinational popcount of registered q, glitch-free relative to q. Range 0..WIDTH, no wrap.
- All channels update in parallel on the same edge; there are no cross-channel interactions except count and conflict.
- Illegal MODE values are unreachable (2-bit). SYNC_STAGES>3 is flagged by an elaboration-time check.

Decomposition:
- Shared package sr_pkg:
  - MODE constants SR_HOLD=0, SR_SET_DOM=1, SR_RST_DOM=2, SR_TOGGLE=3.
  - Function popcount(WIDTH).
- One sub-module sr_cell:
  - Single-channel next-state logic, q register and changed register.
  - Ports: clk, rst, clr, s, r, en, q, changed, conflict_evt; MODE passed down.
- Top instantiates WIDTH sr_cell via generate and holds the synchroniser, conflict OR-reduce/sticky register and count.

Test Plan:
- Reset: WIDTH=8, INIT=8'hA5, assert rst 2 cycles -> q=8'hA5, q_n=8'h5A, count=4, changed=0, conflict=0.
- Basic set/reset, SYNC_STAGES=2, INIT=0:
  - Pulse s=8'h0F, en=8'hFF, 1 cycle -> q=8'h0F two edges later, changed=8'h0F for one cycle, count=4.
  - Then r=8'h03 -> q=8'h0C.
- Gating: en=8'h00, s=8'hFF for 5 cycles -> q unchanged, changed=0; en=8'h80 -> only q[7] sets.
- Conflict per MODE (SYNC_STAGES=0, q[0]=0), s[0]=r[0]=en[0]=1 for 3 cycles:
  - HOLD -> q[0] stays 0.
  - SET_DOM -> 1.
  - RST_DOM -> 0.
  - TOGGLE -> 1,0,1.
  - conflict=1 in all modes; conflict stays 1 until rst.
- clr with q=8'hFF and simultaneous s=8'hFF -> q=0, changed=8'hFF next cycle, count=0.
- rst mid-operation while TOGGLE is running -> q=INIT on that edge, conflict cleared, synchroniser flushed (no stale update in following SYNC_STAGES cycles with inputs low).
